// File: rtl/intt_scheduler.sv
// ---------------------------------------------------------------------------
// intt_scheduler
//
// Sequencer for a shared Kyber inverse-NTT datapath (one Gentleman-Sande
// butterfly, one Montgomery multiplier, one 256-entry dual-port RAM).
// A run issues 7 layers of 128 butterflies (len = 2..128). Each layer is
// followed by a BF_LAT-cycle drain so that its write-backs land before the
// next layer reads. After the last layer come 256 scaling operations by F
// and a MUL_LAT-cycle drain. A one-cycle done pulse ends the run.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   start_ntt    in   run request, sampled only while idle
//   busy         out  run in progress (cycle after start accepted .. done)
//   done_ntt     out  one-cycle completion pulse
//   op_valid     out  op_* fields carry an operation
//   op_ready     in   datapath accepts the op on op_valid & op_ready
//   op_scale     out  0 = butterfly, 1 = scaling op
//   addr_a       out  RAM index j (butterfly) / i (scale)
//   addr_b       out  RAM index j+len (butterfly), 0 for scale
//   zeta_idx     out  zetas[] index for the butterfly, 0 for scale
//   layer        out  current layer 0..6 (len = 2<<layer), 0 otherwise
//   scale_const  out  final scaling constant F (static)
// ---------------------------------------------------------------------------
module intt_scheduler #(
  parameter int N       = 256,
  parameter int Q       = 3329,
  parameter int F       = 3303,
  parameter int BF_LAT  = 4,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_ntt,
  output logic        busy,
  output logic        done_ntt,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_scale,
  output logic [7:0]  addr_a,
  output logic [7:0]  addr_b,
  output logic [6:0]  zeta_idx,
  output logic [2:0]  layer,
  output logic [11:0] scale_const
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_SCALE,
    S_SDRAIN,
    S_DONE
  } state_t;

  localparam logic [6:0] LAST_B     = 7'(N / 2 - 1);
  localparam logic [7:0] LAST_I     = 8'(N - 1);
  localparam logic [2:0] LAST_LAYER = 3'd6;
  localparam logic [3:0] BF_LAST    = 4'(BF_LAT - 1);
  localparam logic [3:0] MUL_LAST   = 4'(MUL_LAT - 1);
  // The datapath expects the constant already reduced into [0, Q).
  localparam int         F_RED      = F % Q;

  state_t     state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] b_q, b_d;
  logic [7:0] i_q, i_d;
  logic [3:0] cnt_q, cnt_d;

  // Butterfly operand addressing derived from the in-layer butterfly count.
  logic [3:0] sh_grp;
  logic [3:0] sh_base;
  logic [7:0] bf_len;
  logic [6:0] bf_grp;
  logic [7:0] bf_off;
  logic [7:0] bf_addr_a;
  logic [7:0] bf_addr_b;
  logic [6:0] bf_zeta;

  always_comb begin
    sh_grp    = {1'b0, layer_q} + 4'd1;
    sh_base   = {1'b0, layer_q} + 4'd2;
    bf_len    = 8'd2 << layer_q;
    bf_grp    = b_q >> sh_grp;
    bf_off    = {1'b0, b_q} & (bf_len - 8'd1);
    bf_addr_a = ({1'b0, bf_grp} << sh_base) + bf_off;
    bf_addr_b = bf_addr_a + bf_len;
    // (128 >> layer) - 1 equals 127 >> layer; keeps the arithmetic 7 bits wide.
    // Zetas are consumed from 127 downwards, one per group.
    bf_zeta   = (7'd127 >> layer_q) - bf_grp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 3'd0;
      b_q     <= 7'd0;
      i_q     <= 8'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      b_q     <= b_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    b_d      = b_q;
    i_d      = i_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done_ntt = 1'b0;
    op_valid = 1'b0;
    op_scale = 1'b0;
    addr_a   = 8'd0;
    addr_b   = 8'd0;
    zeta_idx = 7'd0;
    layer    = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (start_ntt) begin
          state_d = S_ISSUE;
          layer_d = 3'd0;
          b_d     = 7'd0;
        end
      end

      S_ISSUE: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        addr_a   = bf_addr_a;
        addr_b   = bf_addr_b;
        zeta_idx = bf_zeta;
        layer    = layer_q;
        // Counters only move on a handshake, so a stall holds every field.
        if (op_ready) begin
          if (b_q == LAST_B) begin
            state_d = S_DRAIN;
            cnt_d   = 4'd0;
          end else begin
            b_d = b_q + 7'd1;
          end
        end
      end

      S_DRAIN: begin
        // Hold off the next layer until the last butterfly has written back.
        busy  = 1'b1;
        layer = layer_q;
        if (cnt_q == BF_LAST) begin
          if (layer_q == LAST_LAYER) begin
            state_d = S_SCALE;
            i_d     = 8'd0;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            b_d     = 7'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SCALE: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        op_scale = 1'b1;
        addr_a   = i_q;
        if (op_ready) begin
          if (i_q == LAST_I) begin
            state_d = S_SDRAIN;
            cnt_d   = 4'd0;
          end else begin
            i_d = i_q + 8'd1;
          end
        end
      end

      S_SDRAIN: begin
        busy = 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        // start_ntt is deliberately not looked at here; a new run needs IDLE.
        done_ntt = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign scale_const = 12'(F_RED);

endmodule

// File: tb/tb_intt_scheduler.sv
`timescale 1ns/1ps
module tb_intt_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_ntt;
  logic        op_ready;
  logic        busy;
  logic        done_ntt;
  logic        op_valid;
  logic        op_scale;
  logic [7:0]  addr_a;
  logic [7:0]  addr_b;
  logic [6:0]  zeta_idx;
  logic [2:0]  layer;
  logic [11:0] scale_const;

  always #5 clk = ~clk;

  intt_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start_ntt   (start_ntt),
    .busy        (busy),
    .done_ntt    (done_ntt),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_scale    (op_scale),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .zeta_idx    (zeta_idx),
    .layer       (layer),
    .scale_const (scale_const)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // One op packed as {scale, layer, zeta, addr_a, addr_b}.
  logic [26:0] ref_ops [1152];
  logic [26:0] cap_ops [1152];
  int          n_cap;
  int          done_edge;
  int          stall_viol;
  int          gaps [16];
  int          n_gaps;

  typedef struct {
    int         idx;
    logic       s;
    logic [2:0] l;
    logic [6:0] z;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [26:0] pk(input logic s, input logic [2:0] l,
                                     input logic [6:0] z, input logic [7:0] a,
                                     input logic [7:0] b);
    return {s, l, z, a, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference op stream written as the textbook Kyber invntt loop nest.
  task automatic build_ref();
    int n;
    int k;
    int lay;
    n = 0;
    k = 127;
    lay = 0;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ref_ops[n] = pk(1'b0, 3'(lay), 7'(k), 8'(j), 8'(j + len));
          n++;
        end
        k--;
      end
      lay++;
    end
    for (int i = 0; i < 256; i++) begin
      ref_ops[n] = pk(1'b1, 3'd0, 7'd0, 8'(i), 8'd0);
      n++;
    end
  endtask

  task automatic run_once(input bit rand_ready, input bit poke_start);
    int          k;
    bit          prev_stall;
    logic [26:0] prev_f;
    logic [26:0] cur;
    int          gap;
    bit          done_seen;
    n_cap      = 0;
    n_gaps     = 0;
    stall_viol = 0;
    done_edge  = -1;
    prev_stall = 0;
    prev_f     = '0;
    gap        = 0;
    done_seen  = 0;
    @(negedge clk);
    start_ntt = 1'b1;
    op_ready  = 1'b1;
    @(posedge clk);  // start edge
    k = 0;
    while (k < 6000) begin
      @(negedge clk);
      start_ntt = poke_start && (k == 10 || k == 300);
      cur = pk(op_scale, layer, zeta_idx, addr_a, addr_b);
      if (k == 0) begin
        check("busy_after_start", 64'(busy), 64'd1);
        check("valid_after_start", 64'(op_valid), 64'd1);
      end
      if (done_ntt) begin
        // done is high in the cycle that the next edge (edge k+1) samples
        done_edge = k + 1;
        done_seen = 1;
        if (gap > 0 && n_gaps < 16) begin gaps[n_gaps] = gap; n_gaps++; end
        if (poke_start) start_ntt = 1'b1;
        break;
      end
      op_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!op_valid || cur !== prev_f)) stall_viol++;
      if (op_valid) begin
        if (gap > 0) begin
          if (n_gaps < 16) gaps[n_gaps] = gap;
          n_gaps++;
          gap = 0;
        end
      end else if (busy) begin
        gap++;
      end
      if (op_valid && op_ready) begin
        if (n_cap < 1152) cap_ops[n_cap] = cur;
        n_cap++;
      end
      prev_stall = op_valid && !op_ready;
      prev_f     = cur;
      @(posedge clk);
      k++;
    end
    if (!done_seen) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk);  // DONE -> IDLE, start_ntt may be high here
    @(negedge clk);
    start_ntt = 1'b0;
    op_ready  = 1'b1;
    check("busy_low_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("idle_busy_after_done", 64'(busy), 64'd0);
    check("idle_valid_after_done", 64'(op_valid), 64'd0);
  endtask

  task automatic check_run(input string tag, input bit timing);
    int nbad;
    int first_bad;
    nbad = 0;
    first_bad = -1;
    check($sformatf("%s_n_ops", tag), 64'(n_cap), 64'd1152);
    for (int i = 0; i < 1152; i++) begin
      if (cap_ops[i] !== ref_ops[i]) begin
        if (first_bad < 0) first_bad = i;
        nbad++;
      end
    end
    check($sformatf("%s_seq_mismatches_first_at_%0d", tag, first_bad), 64'(nbad), 64'd0);
    foreach (vecs[v]) begin
      check($sformatf("%s_op%0d", tag, vecs[v].idx), 64'(cap_ops[vecs[v].idx]),
            64'(pk(vecs[v].s, vecs[v].l, vecs[v].z, vecs[v].a, vecs[v].b)));
    end
    check($sformatf("%s_n_gaps", tag), 64'(n_gaps), 64'd8);
    for (int g = 0; g < 8; g++) begin
      check($sformatf("%s_gap%0d", tag, g), 64'(gaps[g]), (g < 7) ? 64'd4 : 64'd3);
    end
    check($sformatf("%s_stall_stability", tag), 64'(stall_viol), 64'd0);
    if (timing) check($sformatf("%s_done_edge", tag), 64'(done_edge), 64'd1184);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    vecs[0]  = '{0,    1'b0, 3'd0, 7'd127, 8'd0,   8'd2};
    vecs[1]  = '{1,    1'b0, 3'd0, 7'd127, 8'd1,   8'd3};
    vecs[2]  = '{2,    1'b0, 3'd0, 7'd126, 8'd4,   8'd6};
    vecs[3]  = '{3,    1'b0, 3'd0, 7'd126, 8'd5,   8'd7};
    vecs[4]  = '{63,   1'b0, 3'd0, 7'd96,  8'd125, 8'd127};
    vecs[5]  = '{127,  1'b0, 3'd0, 7'd64,  8'd253, 8'd255};
    vecs[6]  = '{128,  1'b0, 3'd1, 7'd63,  8'd0,   8'd4};
    vecs[7]  = '{130,  1'b0, 3'd1, 7'd63,  8'd2,   8'd6};
    vecs[8]  = '{132,  1'b0, 3'd1, 7'd62,  8'd8,   8'd12};
    vecs[9]  = '{640,  1'b0, 3'd5, 7'd3,   8'd0,   8'd64};
    vecs[10] = '{704,  1'b0, 3'd5, 7'd2,   8'd128, 8'd192};
    vecs[11] = '{768,  1'b0, 3'd6, 7'd1,   8'd0,   8'd128};
    vecs[12] = '{895,  1'b0, 3'd6, 7'd1,   8'd127, 8'd255};
    vecs[13] = '{896,  1'b1, 3'd0, 7'd0,   8'd0,   8'd0};
    vecs[14] = '{1151, 1'b1, 3'd0, 7'd0,   8'd255, 8'd0};
    build_ref();

    rst = 1'b1;
    start_ntt = 1'b0;
    op_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done_ntt), 64'd0);
    check("rst_valid", 64'(op_valid), 64'd0);
    check("rst_fields", 64'({op_scale, layer, zeta_idx, addr_a, addr_b}), 64'd0);
    check("scale_const", 64'(scale_const), 64'd3303);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    run_once(1'b0, 1'b0);
    $display("[TB] run full-ready: %0d ops, done at edge %0d", n_cap, done_edge);
    check_run("ready1", 1'b1);

    run_once(1'b1, 1'b0);
    $display("[TB] run random-ready: %0d ops, done at edge %0d", n_cap, done_edge);
    check_run("randready", 1'b0);

    run_once(1'b0, 1'b1);
    $display("[TB] run start-poke: %0d ops, done at edge %0d", n_cap, done_edge);
    check_run("poke", 1'b1);

    // Asynchronous reset in the middle of layer 3.
    @(negedge clk);
    start_ntt = 1'b1;
    op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_ntt = 1'b0;
    guard = 0;
    while (!(op_valid && layer == 3'd3) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    check("pre_rst_layer3", 64'(layer), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_valid", 64'(op_valid), 64'd0);
    check("async_rst_fields", 64'({op_scale, layer, zeta_idx, addr_a, addr_b}), 64'd0);
    $display("[TB] async reset mid-layer-3 applied");
    @(negedge clk);
    rst = 1'b0;

    run_once(1'b0, 1'b0);
    $display("[TB] run after reset: %0d ops, done at edge %0d", n_cap, done_edge);
    check_run("rerun", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
